accum_seq: RTL and testbench
============================

ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 Parameter: WIDTH, 16, width of every operand, accumulator and result.
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: RESET_N  input  1  asynchronous, active-low reset.
REQ-004 Port: START  input  1  request to compute one SE/SEZ pair; sampled on rising CLK.
REQ-005 Port: WB1..WB6  input  WIDTH each  zero-section weighted terms.
REQ-006 Port: WA1, WA2  input  WIDTH each  pole-section weighted terms.
REQ-007 Port: BUSY  output  1  high while a computation is in progress (ACC state).
REQ-008 Port: DONE  output  1  one-cycle pulse marking new SE/SEZ valid.
REQ-009 Port: SEZ  output  WIDTH  {1'b0, SEZI[WIDTH-1:1]}, where SEZI = WB1+...+WB6 mod 2^WIDTH.
REQ-010 Port: SE  output  WIDTH  {1'b0, SEI[WIDTH-1:1]}, where SEI = SEZI+WA1+WA2 mod 2^WIDTH.

Function
REQ-011 The block SHALL implement a single WIDTH-bit adder, time-shared across all eight terms; no parallel multi-operand sum.
REQ-012 States SHALL be IDLE, ACC and DONE; reset state is IDLE.
REQ-013 In IDLE or DONE, START=1 on an edge SHALL latch all eight operands into internal registers, clear the accumulator, set term index to 0 and enter ACC.
REQ-014 In ACC, each edge SHALL add exactly one latched term, in order WB1, WB2, WB3, WB4, WB5, WB6, WA1, WA2 (index 0..7), and increment the index.
REQ-015 On the edge adding WB6 (index 5), the block SHALL capture the post-add sum into an internal SEZI holding register.
REQ-016 On the edge adding WA2 (index 7), the block SHALL load SEZ from the SEZI register, load SE from the post-add sum, and enter DONE.
REQ-017 All additions SHALL wrap modulo 2^WIDTH; carries are discarded; no saturation.
REQ-018 Latency: with START sampled at edge E0, DONE SHALL be high between E8 and E9; SE/SEZ change at E8 only.
REQ-019 DONE SHALL be high only in DONE state (exactly one cycle); BUSY SHALL be high only in ACC state.
REQ-020 From DONE, START=0 SHALL return to IDLE; START=1 SHALL begin a new computation (back-to-back rate one result per 9 cycles).
REQ-021 START while in ACC SHALL be ignored; the ongoing computation and latched operands SHALL be unaffected.
REQ-022 Operand input changes after the latching edge SHALL not affect the in-flight result.
REQ-023 SE and SEZ SHALL hold their last values in IDLE and ACC until the next index-7 edge.

Reset
REQ-024 RESET_N=0 SHALL immediately, independent of CLK, force state IDLE, index 0, accumulator 0, SEZI register 0, SE=0, SEZ=0, BUSY=0, DONE=0.
REQ-025 Reset asserted mid-computation SHALL abandon it; no DONE pulse SHALL follow release.
REQ-026 After RESET_N deasserts, the first rising edge with START=1 SHALL be accepted as in REQ-013.

Verification
REQ-027 All operands 0, START pulse at E0 -> BUSY high E0..E8, DONE high E8..E9, SE=0x0000, SEZ=0x0000.
REQ-028 WB1..WB6=0x0001, WA1=WA2=0x0002 -> SEZ=0x0003, SE=0x0005 at E8.
REQ-029 Wrap: WB1..WB6=0x4000, WA1=WA2=0x0000 -> SEZI=0x8000, SEZ=0x4000, SE=0x4000.
REQ-030 Negative terms: WB1=0xFFFF, WA1=0xFFFF, others 0 -> SEZ=0x7FFF, SE=0x7FFF.
REQ-031 After START, change all operands to 0xFFFF and pulse START at E3 -> result matches originally latched operands; DONE only at E8.
REQ-032 RESET_N low between E4 and E5 -> outputs all 0 immediately, no DONE thereafter; START at E0 in DONE cycle of a prior run -> second DONE exactly 9 cycles after first.

Source files
------------

// File: rtl/accum_seq.sv
// Eight-term SE/SEZ accumulator: one WIDTH-bit adder walks the latched WB1..WB6, WA1, WA2
// terms over eight cycles. SEZ and SE are the halved wrap-around sums.
module accum_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] wb1,
  input  logic [WIDTH-1:0] wb2,
  input  logic [WIDTH-1:0] wb3,
  input  logic [WIDTH-1:0] wb4,
  input  logic [WIDTH-1:0] wb5,
  input  logic [WIDTH-1:0] wb6,
  input  logic [WIDTH-1:0] wa1,
  input  logic [WIDTH-1:0] wa2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sez,
  output logic [WIDTH-1:0] se
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] IDX_SEZ  = 3'd5;
  localparam logic [2:0] IDX_LAST = 3'd7;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ops [8];
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [2:0]       idx;
  // Only the bits that survive the final halving are kept for SEZ.
  logic [WIDTH-2:0] sezi_hi;
  logic             accept;

  // START is only honoured outside ACC, so an in-flight run cannot be disturbed.
  assign accept = start && (state != S_ACC);

  // The single shared adder.
  assign addend = ops[idx];
  assign sum    = acc + addend;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: a default at the top of every always_comb keeps all paths assigned and avoids latches.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ACC;
      S_ACC:   if (idx == IDX_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_ACC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ACC);
    done = (state == S_DONE);
  end

  // NOTE: operand registers carry no reset; they are always reloaded before being summed.
  always_ff @(posedge clk) begin
    if (accept) ops <= '{wb1, wb2, wb3, wb4, wb5, wb6, wa1, wa2};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      idx     <= '0;
      sezi_hi <= '0;
      sez     <= '0;
      se      <= '0;
    end else if (accept) begin
      acc <= '0;
      idx <= '0;
    end else if (state == S_ACC) begin
      acc <= sum;
      idx <= idx + 3'd1;
      if (idx == IDX_SEZ) sezi_hi <= sum[WIDTH-1:1];
      if (idx == IDX_LAST) begin
        sez <= {1'b0, sezi_hi};
        se  <= {1'b0, sum[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq: directed corner cases plus randomized runs
// compared against a plain-arithmetic model of the SE/SEZ sums.
module tb_accum_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] op [8];
  logic        busy, done;
  logic [15:0] sez, se;

  int checks   = 0;
  int failures = 0;

  // Results the bench expects the DUT to be holding.
  logic [15:0] model_sez = '0;
  logic [15:0] model_se  = '0;

  accum_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .wb1(op[0]), .wb2(op[1]), .wb3(op[2]), .wb4(op[3]), .wb5(op[4]), .wb6(op[5]),
    .wa1(op[6]), .wa2(op[7]),
    .busy(busy), .done(done), .sez(sez), .se(se)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SEZI = sum of WB terms, SEI = SEZI + WA terms, both mod 2^16, outputs halved.
  function automatic void ref_calc(output logic [15:0] e_sez, output logic [15:0] e_se);
    int unsigned s;
    int unsigned sezi;
    int unsigned sei;
    s = 0;
    for (int i = 0; i < 6; i++) s += op[i];
    sezi  = s % 65536;
    sei   = (sezi + op[6] + op[7]) % 65536;
    e_sez = 16'(sezi / 2);
    e_se  = 16'(sei / 2);
  endfunction

  task automatic set_ops(input logic [15:0] wb, input logic [15:0] wa);
    for (int i = 0; i < 6; i++) op[i] = wb;
    op[6] = wa;
    op[7] = wa;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 8; i++) op[i] = 16'($urandom);
  endtask

  // Called at a negedge with operands driven. mode 1 corrupts operands after the
  // latching edge and pulses START at E3. If started=1 the caller already raised START.
  task automatic run_one(input string tag, input int mode, input bit started);
    logic [15:0] e_sez, e_se;
    ref_calc(e_sez, e_se);
    if (!started) start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    if (mode == 1) for (int i = 0; i < 8; i++) op[i] = 16'hFFFF;
    for (int k = 1; k <= 8; k++) begin
      if (mode == 1) start = (k == 3);   // high across E3
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== (k < 8)) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy, (k < 8));
      end
      checks++;
      if (done !== (k == 8)) begin
        failures++;
        $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, (k == 8));
      end
      if (k == 4 || k == 7) begin
        checks++;
        if (se !== model_se || sez !== model_sez) begin
          failures++;
          $display("FAIL %s hold k=%0d got se=%h sez=%h exp se=%h sez=%h",
                   tag, k, se, sez, model_se, model_sez);
        end
      end
    end
    start = 1'b0;
    model_sez = e_sez;
    model_se  = e_se;
    checks++;
    if (sez !== e_sez) begin
      failures++;
      $display("FAIL %s sez got=%h exp=%h", tag, sez, e_sez);
    end
    checks++;
    if (se !== e_se) begin
      failures++;
      $display("FAIL %s se got=%h exp=%h", tag, se, e_se);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || se !== 16'h0 || sez !== 16'h0) begin
      failures++;
      $display("FAIL %s got busy=%b done=%b se=%h sez=%h exp all zero", tag, busy, done, se, sez);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    set_ops(16'h1234, 16'h5678);
    #2;
    check_zero_outputs("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_held");
    start = 1'b0;
    reset_n = 1'b1;
    model_se = '0;
    model_sez = '0;
    @(negedge clk);
    check_zero_outputs("reset_release");
  endtask

  task automatic test_directed();
    set_ops(16'h0000, 16'h0000);
    run_one("all_zero", 0, 1'b0);
    @(negedge clk);
    set_ops(16'h0001, 16'h0002);
    run_one("ones_twos", 0, 1'b0);
    check_idle("after_ones");
    set_ops(16'h4000, 16'h0000);
    run_one("wrap", 0, 1'b0);
    @(negedge clk);
    set_ops(16'h0000, 16'h0000);
    op[0] = 16'hFFFF;
    op[6] = 16'hFFFF;
    run_one("negative", 0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s idle got busy=%b done=%b exp 0 0", tag, busy, done);
    end
  endtask

  task automatic test_in_flight();
    @(negedge clk);
    rand_ops();
    run_one("in_flight", 1, 1'b0);
    check_idle("after_in_flight");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rand_ops();
    op[0] = 16'h0101;                      // keep the abandoned result nonzero
    start = 1'b1;
    @(posedge clk);                        // E0
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);             // E1..E4
    #2;
    reset_n = 1'b0;
    #1;
    model_se = '0;
    model_sez = '0;
    check_zero_outputs("reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_no_done k=%0d got busy=%b done=%b exp 0 0", k, busy, done);
      end
    end
    set_ops(16'h0001, 16'h0002);
    run_one("after_reset_mid", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rand_ops();
    run_one("b2b_first", 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      // Still in the DONE cycle: request the next run immediately.
      rand_ops();
      start = 1'b1;
      run_one("b2b_next", 0, 1'b1);
    end
    check_idle("after_b2b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      rand_ops();
      if (r % 5 == 0) op[$urandom_range(0, 7)] = 16'hFFFF;
      run_one("random", 0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_in_flight();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
